// File: rtl/tone_sequencer.sv
// ---------------------------------------------------------------------------
// tone_sequencer
//   Plays a stored sequence of {period, duration} notes into a downstream
//   PWM tone generator. Every note is driven at 50% duty, and a zero period
//   is a rest. A zero duration marks the end of the sequence.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   wr_en      sequence RAM write strobe
//   wr_addr    entry index to write
//   wr_period  note period in clocks (0 = rest)
//   wr_dur     note length in ticks (0 = end-of-sequence marker)
//   start      begin playback from entry 0 (only looked at in IDLE)
//   stop       abort playback in any state; no done pulse
//   loop       sampled at end of sequence; 1 = restart from entry 0
//   period     period to the PWM stage
//   compare    compare to the PWM stage, always period >> 1
//   mute       high when no tone is sounding
//   busy       high whenever not IDLE
//   done       one-cycle pulse on natural completion
//   note_idx   index of the entry currently sounding
// ---------------------------------------------------------------------------
module tone_sequencer #(
    parameter int MAX_WAVE = 24,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [MAX_WAVE-1:0] wr_period,
    input  logic [DUR_W-1:0]    wr_dur,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    output logic [MAX_WAVE-1:0] period,
    output logic [MAX_WAVE-1:0] compare,
    output logic                mute,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       note_idx
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0]    IDX_LAST  = AW'(DEPTH - 1);
    localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CHECK = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    // Sequence RAM: {period, dur} per entry, not reset.
    logic [MAX_WAVE+DUR_W-1:0] r_mem [DEPTH];
    logic [MAX_WAVE+DUR_W-1:0] r_rd_data;

    state_t                r_state;
    logic [AW-1:0]         r_idx;
    logic [DUR_W-1:0]      r_dur_ctr;
    logic [TW-1:0]         r_tick_ctr;
    logic [MAX_WAVE-1:0]   r_period;
    logic [MAX_WAVE-1:0]   r_compare;
    logic                  r_mute;
    logic                  r_done;
    logic [AW-1:0]         r_note_idx;

    logic [MAX_WAVE-1:0]   w_rd_period;
    logic [DUR_W-1:0]      w_rd_dur;
    logic                  w_loop_back;

    assign w_rd_period = r_rd_data[MAX_WAVE+DUR_W-1:DUR_W];
    assign w_rd_dur    = r_rd_data[DUR_W-1:0];
    // Entry 0 terminating with loop set would spin forever with no sound,
    // so looping is only allowed once at least one entry has been passed.
    assign w_loop_back = loop && (r_idx != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= {wr_period, wr_dur};
        end
    end

    // Read only during FETCH so CHECK sees the entry as it was at fetch time;
    // later writes to the same entry apply on the next fetch of it.
    always_ff @(posedge clk) begin
        if (r_state == ST_FETCH) begin
            r_rd_data <= r_mem[r_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_dur_ctr  <= '0;
            r_tick_ctr <= '0;
            r_period   <= '0;
            r_compare  <= '0;
            r_mute     <= 1'b1;
            r_done     <= 1'b0;
            r_note_idx <= '0;
        end else begin
            r_done <= 1'b0;
            if (stop && (r_state != ST_IDLE)) begin
                r_state   <= ST_IDLE;
                r_period  <= '0;
                r_compare <= '0;
                r_mute    <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            r_idx   <= '0;
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        r_state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (w_rd_dur == '0) begin
                            if (w_loop_back) begin
                                r_idx   <= '0;
                                r_state <= ST_FETCH;
                            end else begin
                                r_period  <= '0;
                                r_compare <= '0;
                                r_mute    <= 1'b1;
                                r_done    <= 1'b1;
                                r_state   <= ST_IDLE;
                            end
                        end else begin
                            r_period   <= w_rd_period;
                            r_compare  <= w_rd_period >> 1;
                            r_mute     <= (w_rd_period == '0);
                            r_note_idx <= r_idx;
                            r_dur_ctr  <= w_rd_dur;
                            r_tick_ctr <= '0;
                            r_state    <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (r_tick_ctr == TICK_LAST) begin
                            r_tick_ctr <= '0;
                            r_dur_ctr  <= r_dur_ctr - DUR_ONE;
                            if (r_dur_ctr == DUR_ONE) begin
                                if (r_idx != IDX_LAST) begin
                                    r_idx   <= r_idx + 1'b1;
                                    r_state <= ST_FETCH;
                                end else if (w_loop_back) begin
                                    r_idx   <= '0;
                                    r_state <= ST_FETCH;
                                end else begin
                                    r_period  <= '0;
                                    r_compare <= '0;
                                    r_mute    <= 1'b1;
                                    r_done    <= 1'b1;
                                    r_state   <= ST_IDLE;
                                end
                            end
                        end else begin
                            r_tick_ctr <= r_tick_ctr + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign period   = r_period;
    assign compare  = r_compare;
    assign mute     = r_mute;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign note_idx = r_note_idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tone_sequencer
//   Directed testbench for tone_sequencer with TICK_DIV=4. Cycle N is the
//   N-th clock after the edge that sampled start; outputs are sampled on
//   the falling edge, inputs are driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_tone_sequencer;

    localparam int MAX_WAVE = 24;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int DUR_W    = 8;
    localparam int TICK_DIV = 4;

    logic                clk;
    logic                rst;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [MAX_WAVE-1:0] wr_period;
    logic [DUR_W-1:0]    wr_dur;
    logic                start;
    logic                stop;
    logic                loop;
    logic [MAX_WAVE-1:0] period;
    logic [MAX_WAVE-1:0] compare;
    logic                mute;
    logic                busy;
    logic                done;
    logic [AW-1:0]       note_idx;

    int checks;
    int failures;

    tone_sequencer #(
        .MAX_WAVE (MAX_WAVE),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_period (wr_period),
        .wr_dur    (wr_dur),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .period    (period),
        .compare   (compare),
        .mute      (mute),
        .busy      (busy),
        .done      (done),
        .note_idx  (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_entry(input int addr, input int per, input int dur);
        wr_en     = 1'b1;
        wr_addr   = AW'(addr);
        wr_period = MAX_WAVE'(per);
        wr_dur    = DUR_W'(dur);
        @(negedge clk);
        wr_en = 1'b0;
        $display("write e%0d = {%0d,%0d}", addr, per, dur);
    endtask

    // Pulses start; returns in cycle 1.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        checks++; if (period !== 24'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
        checks++; if (compare !== 24'd0) begin failures++; $display("FAIL reset_compare got=%0d exp=0", compare); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL reset_mute got=%b exp=1", mute); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (note_idx !== 4'd0) begin failures++; $display("FAIL reset_note_idx got=%0d exp=0", note_idx); end
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        write_entry(0, 1000, 2);
        write_entry(1, 600, 1);
        write_entry(2, 0, 0);
        loop = 1'b0;
        pulse_start();                                   // cycle 1
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_c1 got=%b exp=1", busy); end
        checks++; if (period !== 24'd0) begin failures++; $display("FAIL basic_period_c1 got=%0d exp=0", period); end
        step(2);                                         // cycle 3
        checks++; if (period !== 24'd1000) begin failures++; $display("FAIL basic_period_c3 got=%0d exp=1000", period); end
        checks++; if (compare !== 24'd500) begin failures++; $display("FAIL basic_compare_c3 got=%0d exp=500", compare); end
        checks++; if (mute !== 1'b0) begin failures++; $display("FAIL basic_mute_c3 got=%b exp=0", mute); end
        checks++; if (note_idx !== 4'd0) begin failures++; $display("FAIL basic_idx_c3 got=%0d exp=0", note_idx); end
        step(9);                                         // cycle 12: still held
        checks++; if (period !== 24'd1000) begin failures++; $display("FAIL basic_hold_c12 got=%0d exp=1000", period); end
        step(1);                                         // cycle 13
        checks++; if (period !== 24'd600) begin failures++; $display("FAIL basic_period_c13 got=%0d exp=600", period); end
        checks++; if (compare !== 24'd300) begin failures++; $display("FAIL basic_compare_c13 got=%0d exp=300", compare); end
        checks++; if (note_idx !== 4'd1) begin failures++; $display("FAIL basic_idx_c13 got=%0d exp=1", note_idx); end
        step(5);                                         // cycle 18
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_c18 got=%b exp=0", done); end
        checks++; if (period !== 24'd600) begin failures++; $display("FAIL basic_period_c18 got=%0d exp=600", period); end
        step(1);                                         // cycle 19
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_c19 got=%b exp=1", done); end
        checks++; if (period !== 24'd0) begin failures++; $display("FAIL basic_period_c19 got=%0d exp=0", period); end
        checks++; if (compare !== 24'd0) begin failures++; $display("FAIL basic_compare_c19 got=%0d exp=0", compare); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL basic_mute_c19 got=%b exp=1", mute); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_c19 got=%b exp=0", busy); end
        step(1);                                         // cycle 20
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_c20 got=%b exp=0", done); end
        $display("test_basic complete");
    endtask

    task automatic test_rest();
        write_entry(0, 0, 1);
        write_entry(1, 0, 0);
        pulse_start();
        step(2);                                         // cycle 3
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL rest_mute got=%b exp=1", mute); end
        checks++; if (period !== 24'd0) begin failures++; $display("FAIL rest_period got=%0d exp=0", period); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rest_busy got=%b exp=1", busy); end
        step(5);                                         // cycle 8
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rest_done_c8 got=%b exp=0", done); end
        step(1);                                         // cycle 9
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rest_done_c9 got=%b exp=1", done); end
        $display("test_rest complete");
    endtask

    task automatic test_period_one();
        write_entry(0, 1, 1);
        write_entry(1, 0, 0);
        pulse_start();
        step(2);                                         // cycle 3
        checks++; if (period !== 24'd1) begin failures++; $display("FAIL p1_period got=%0d exp=1", period); end
        checks++; if (compare !== 24'd0) begin failures++; $display("FAIL p1_compare got=%0d exp=0", compare); end
        checks++; if (mute !== 1'b0) begin failures++; $display("FAIL p1_mute got=%b exp=0", mute); end
        step(6);                                         // cycle 9
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL p1_done got=%b exp=1", done); end
        $display("test_period_one complete");
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < DEPTH; i++) write_entry(i, 100 + 10 * i, 1);
        loop = 1'b0;
        pulse_start();
        step(2);                                         // cycle 3
        checks++; if (period !== 24'd100) begin failures++; $display("FAIL full_period_e0 got=%0d exp=100", period); end
        step(90);                                        // cycle 93: entry 15
        checks++; if (note_idx !== 4'd15) begin failures++; $display("FAIL full_idx_e15 got=%0d exp=15", note_idx); end
        checks++; if (period !== 24'd250) begin failures++; $display("FAIL full_period_e15 got=%0d exp=250", period); end
        step(3);                                         // cycle 96
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL full_done_c96 got=%b exp=0", done); end
        step(1);                                         // cycle 97
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done_c97 got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_c97 got=%b exp=0", busy); end
        checks++; if (note_idx !== 4'd15) begin failures++; $display("FAIL full_idx_c97 got=%0d exp=15", note_idx); end
        step(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%b exp=0", busy); end
        $display("test_full_depth loop=0 complete");

        loop = 1'b1;
        pulse_start();                                   // cycle 1
        step(96);                                        // cycle 97
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL loop_busy_c97 got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL loop_done_c97 got=%b exp=0", done); end
        checks++; if (period !== 24'd250) begin failures++; $display("FAIL loop_hold_c97 got=%0d exp=250", period); end
        step(2);                                         // cycle 99
        checks++; if (note_idx !== 4'd0) begin failures++; $display("FAIL loop_idx_c99 got=%0d exp=0", note_idx); end
        checks++; if (period !== 24'd100) begin failures++; $display("FAIL loop_period_c99 got=%0d exp=100", period); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL loop_busy_c99 got=%b exp=1", busy); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL loop_stop_busy got=%b exp=0", busy); end
        $display("test_full_depth loop=1 complete");
    endtask

    task automatic test_stop();
        write_entry(0, 1000, 1);
        write_entry(1, 600, 2);
        write_entry(2, 0, 0);
        pulse_start();
        step(8);                                         // cycle 9: e1 sounding
        checks++; if (period !== 24'd600) begin failures++; $display("FAIL stop_pre_period got=%0d exp=600", period); end
        step(1);                                         // cycle 10
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", busy); end
        checks++; if (period !== 24'd0) begin failures++; $display("FAIL stop_period got=%0d exp=0", period); end
        checks++; if (compare !== 24'd0) begin failures++; $display("FAIL stop_compare got=%0d exp=0", compare); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL stop_mute got=%b exp=1", mute); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_done got=%b exp=0", done); end
        step(1);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL stop_done_next got=%b exp=0", done); end
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy got=%b exp=0", busy); end
        step(2);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL startstop_busy_later got=%b exp=0", busy); end
        checks++; if (period !== 24'd0) begin failures++; $display("FAIL startstop_period got=%0d exp=0", period); end
        $display("test_stop complete");
    endtask

    task automatic test_write_busy_and_reset();
        write_entry(0, 1000, 2);
        write_entry(1, 600, 1);
        write_entry(2, 0, 0);
        pulse_start();
        step(3);                                         // cycle 4: e0 playing
        write_entry(1, 800, 1);                          // now cycle 5
        step(8);                                         // cycle 13
        checks++; if (period !== 24'd800) begin failures++; $display("FAIL wrbusy_period got=%0d exp=800", period); end
        checks++; if (compare !== 24'd400) begin failures++; $display("FAIL wrbusy_compare got=%0d exp=400", compare); end
        checks++; if (note_idx !== 4'd1) begin failures++; $display("FAIL wrbusy_idx got=%0d exp=1", note_idx); end
        step(1);                                         // cycle 14: in PLAY
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (period !== 24'd0) begin failures++; $display("FAIL midrst_period got=%0d exp=0", period); end
        checks++; if (compare !== 24'd0) begin failures++; $display("FAIL midrst_compare got=%0d exp=0", compare); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL midrst_mute got=%b exp=1", mute); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (note_idx !== 4'd0) begin failures++; $display("FAIL midrst_idx got=%0d exp=0", note_idx); end
        $display("test_write_busy_and_reset complete");
    endtask

    task automatic test_zero_entry_loop();
        write_entry(0, 500, 0);
        loop = 1'b1;
        pulse_start();                                   // cycle 1
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_c1 got=%b exp=1", busy); end
        step(1);                                         // cycle 2
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_c2 got=%b exp=0", done); end
        step(1);                                         // cycle 3
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done_c3 got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_c3 got=%b exp=0", busy); end
        checks++; if (mute !== 1'b1) begin failures++; $display("FAIL zero_mute_c3 got=%b exp=1", mute); end
        step(1);                                         // cycle 4
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_c4 got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_c4 got=%b exp=0", done); end
        loop = 1'b0;
        $display("test_zero_entry_loop complete");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_period = '0;
        wr_dur    = '0;
        start     = 1'b0;
        stop      = 1'b0;
        loop      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_rest();
        test_period_one();
        test_full_depth();
        test_stop();
        test_write_busy_and_reset();
        test_zero_entry_loop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
